tri_issue_driver: RTL and testbench
===================================

Name: tri_issue_driver

Overview:
- Transmit end of the rasterizer input interface: buffers triangles from a loader port and issues them into the rasterizer front end (R10) under `halt_RnnnnL` backpressure.
- Brackets each frame: after the last triangle is issued, waits for the pipeline to drain, then pulses `frame_done`.
- Keeps issue-side performance counters (triangles issued, stall cycles, bubble cycles) to complement the sample-side counters on the output end.

Parameters:
- SIGFIG, 24, bits per coordinate/colour value
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, colour channels
- FIFO_DEPTH, 4, triangle buffer entries; power of 2, >=2
- DRAIN_CYCLES, 8, consecutive non-halted cycles after the last issue before `frame_done`; >=1
- CNT_W, 32, perf counter width

Ports:
- clk, input, 1, clock
- rst, input, 1, reset, asynchronous, active-low
- ld_valid, input, 1, loader offers a triangle
- ld_ready, output, 1, buffer can accept (= !full)
- ld_tri, input, VERTS*AXIS*SIGFIG, vertex data, vertex-major, axis-minor, v0.x at LSBs
- ld_color, input, COLORS*SIGFIG, colour, channel 0 at LSBs
- ld_last, input, 1, triangle is last of frame
- tri_R10S, output, VERTS*AXIS*SIGFIG, issued vertex data
- color_R10U, output, COLORS*SIGFIG, issued colour
- validTri_R10H, output, 1, issued triangle valid
- halt_RnnnnL, input, 1, downstream accepts when 1; stall when 0
- frame_done, output, 1, one-cycle pulse at end of frame
- cnt_clr, input, 1, synchronous clear of perf counters
- tri_issued_cnt, output, CNT_W, triangles transferred
- stall_cnt, output, CNT_W, cycles with valid && !halt
- bubble_cnt, output, CNT_W, SEND cycles with FIFO empty && halt

Behaviour:
- **Reset** (rst=0, async): state=IDLE; FIFO empty; counters 0; `validTri_R10H`=0; `frame_done`=0; `tri_R10S`/`color_R10U`=0; `ld_ready`=1.
- **Load handshake:** push when `ld_valid && ld_ready`. `ld_ready` = !full, from registered pointers. No push while full, including a same-cycle pop. The entry stores {tri, color, last}.
- **Transfer rule:** a transfer occurs when `validTri_R10H && halt_RnnnnL`; the head entry pops on a transfer.
- **Stall hold:** while valid && !halt, all outputs hold bit-stable until transfer.
- **Output gating:** `validTri_R10H` = (state==SEND) && !empty. Data outputs = FIFO head when valid, else 0.
- **Latency:** a push into an empty FIFO in SEND is visible as valid on the next cycle. A push and a pop in the same cycle keep the count unchanged.
- **State IDLE:** valid=0. Go to SEND when !empty.
- **State SEND:** issue the head.
  - On a transfer of an entry with last=1, go to DRAIN.
  - Otherwise stay in SEND, including when the FIFO becomes empty.
- **State DRAIN:** valid=0.
  - Loads are still accepted into the FIFO but not issued.
  - `drain_ctr` increments on each cycle with `halt_RnnnnL`=1 and resets to 0 on `halt_RnnnnL`=0.
  - When `drain_ctr` reaches DRAIN_CYCLES, go to DONE.
- **State DONE:** `frame_done`=1 for exactly this cycle; valid=0; next state is IDLE.
- **Perf counters:**
  - `tri_issued_cnt` +1 per transfer.
  - `stall_cnt` +1 per valid && !halt cycle.
  - `bubble_cnt` +1 per cycle with state==SEND, empty, halt=1.
  - All counters saturate at 2^CNT_W-1; no wrap.
  - `cnt_clr`=1 zeroes all counters next cycle and takes priority over a same-cycle increment.
  - Counters are not cleared by `frame_done`.
- **Pointers:** log2(FIFO_DEPTH)+1 bits; wrap modulo 2*FIFO_DEPTH. full = MSBs differ and LSBs equal; empty = all bits equal.
- **Reset mid-operation:** async reset discards FIFO contents and any in-flight frame. `frame_done` is not pulsed.

Test Plan:
- **Single triangle:** load 1 triangle with last=1, halt=1 throughout. Required:
  - valid high for 1 cycle, 1 cycle after the push.
  - `tri_issued_cnt`=1.
  - `frame_done` pulses exactly DRAIN_CYCLES+1 cycles after the transfer cycle.
- **Backpressure:** 3 triangles preloaded; halt=0 for 5 cycles while valid. Required:
  - outputs hold stable.
  - `stall_cnt`=5.
  - after halt=1, 3 transfers on consecutive cycles; `tri_issued_cnt`=3.
- **Full FIFO:** push 4 with halt=0. Required:
  - `ld_ready`=0 after the 4th push.
  - 5th offer is not accepted until a pop.
  - order is preserved (v0.x = 1, 2, 3, 4, 5 observed in sequence).
- **Drain interruption:** DRAIN_CYCLES=8; halt drops for 1 cycle after 5 drain cycles. Required: `drain_ctr` restarts; `frame_done` occurs only after 8 further consecutive halt=1 cycles.
- **Bubbles:** frame of 2 triangles with a 3-cycle load gap between them, halt=1. Required: `bubble_cnt`=3.
- **Counter controls:** `cnt_clr` asserted in the same cycle as a transfer → all counters read 0 next cycle. Counters preset near max → `tri_issued_cnt` saturates at 0xFFFFFFFF. Reset asserted mid-frame → valid=0 immediately, `ld_ready`=1, no `frame_done`.

Source files
------------

// File: rtl/tri_issue_driver.sv
// Rasterizer input transmit end: buffers loader triangles, issues them under halt
// backpressure, brackets each frame with a drain wait and a frame_done pulse.
`timescale 1ns/1ps
module tri_issue_driver #(
    parameter int unsigned SIGFIG       = 24,
    parameter int unsigned VERTS        = 3,
    parameter int unsigned AXIS         = 3,
    parameter int unsigned COLORS       = 3,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [VERTS*AXIS*SIGFIG-1:0]     ld_tri,
    input  logic [COLORS*SIGFIG-1:0]         ld_color,
    input  logic                             ld_last,
    output logic [VERTS*AXIS*SIGFIG-1:0]     tri_R10S,
    output logic [COLORS*SIGFIG-1:0]         color_R10U,
    output logic                             validTri_R10H,
    input  logic                             halt_RnnnnL,
    output logic                             frame_done,
    input  logic                             cnt_clr,
    output logic [CNT_W-1:0]                 tri_issued_cnt,
    output logic [CNT_W-1:0]                 stall_cnt,
    output logic [CNT_W-1:0]                 bubble_cnt
);

    localparam int unsigned TRI_W = VERTS * AXIS * SIGFIG;
    localparam int unsigned COL_W = COLORS * SIGFIG;
    localparam int unsigned ENT_W = TRI_W + COL_W + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DW    = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    state_t           state;
    logic [DW-1:0]    drain_ctr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [ENT_W-1:0] head;
    logic             empty;
    logic             full;
    logic             push;
    logic             xfer;
    logic             valid;

    // Extra pointer MSB distinguishes full from empty when the indices coincide
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = ld_valid && !full;
    assign valid = (state == SEND) && !empty;
    assign xfer  = valid && halt_RnnnnL;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign ld_ready      = !full;
    assign validTri_R10H = valid;
    assign tri_R10S      = valid ? head[ENT_W-1 -: TRI_W] : '0;
    assign color_R10U    = valid ? head[COL_W:1] : '0;
    assign frame_done    = (state == DONE);

    // Entry storage; contents are only observed through the valid gate
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ld_tri, ld_color, ld_last};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (xfer) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Frame sequencing: issue until the last triangle leaves, then wait for the drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_ctr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) state <= SEND;
                end
                SEND: begin
                    if (xfer && head[0]) begin
                        state     <= DRAIN;
                        drain_ctr <= '0;
                    end
                end
                DRAIN: begin
                    if (!halt_RnnnnL) begin
                        drain_ctr <= '0;
                    end else if (drain_ctr == DW'(DRAIN_CYCLES - 1)) begin
                        state     <= DONE;
                        drain_ctr <= '0;
                    end else begin
                        drain_ctr <= drain_ctr + DW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating perf counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_issued_cnt <= '0;
            stall_cnt      <= '0;
            bubble_cnt     <= '0;
        end else if (cnt_clr) begin
            tri_issued_cnt <= '0;
            stall_cnt      <= '0;
            bubble_cnt     <= '0;
        end else begin
            if (xfer && (tri_issued_cnt != '1))
                tri_issued_cnt <= tri_issued_cnt + CNT_W'(1);
            if (valid && !halt_RnnnnL && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((state == SEND) && empty && halt_RnnnnL && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tri_issue_driver.sv
// Bench for tri_issue_driver: directed scenarios plus random traffic against a
// queue-based transaction model of the issue interface.
`timescale 1ns/1ps
module tb_tri_issue_driver;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DC     = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned TRI_W  = VERTS * AXIS * SIGFIG;
    localparam int unsigned COL_W  = COLORS * SIGFIG;
    localparam longint unsigned MAXC = 64'h0000_0000_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [TRI_W-1:0] ld_tri = '0;
    logic [COL_W-1:0] ld_color = '0;
    logic             ld_last = 1'b0;
    logic [TRI_W-1:0] tri_R10S;
    logic [COL_W-1:0] color_R10U;
    logic             validTri_R10H;
    logic             halt_RnnnnL = 1'b1;
    logic             frame_done;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] tri_issued_cnt, stall_cnt, bubble_cnt;

    // Narrow-counter twin sharing all inputs, used to observe saturation
    logic             s_ld_ready, s_valid, s_frame_done;
    logic [TRI_W-1:0] s_tri;
    logic [COL_W-1:0] s_color;
    logic [1:0]       s_iss, s_stall, s_bub;

    tri_issue_driver #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                       .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_tri(ld_tri), .ld_color(ld_color), .ld_last(ld_last),
        .tri_R10S(tri_R10S), .color_R10U(color_R10U), .validTri_R10H(validTri_R10H),
        .halt_RnnnnL(halt_RnnnnL), .frame_done(frame_done), .cnt_clr(cnt_clr),
        .tri_issued_cnt(tri_issued_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

    tri_issue_driver #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                       .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DC), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(s_ld_ready),
        .ld_tri(ld_tri), .ld_color(ld_color), .ld_last(ld_last),
        .tri_R10S(s_tri), .color_R10U(s_color), .validTri_R10H(s_valid),
        .halt_RnnnnL(halt_RnnnnL), .frame_done(s_frame_done), .cnt_clr(cnt_clr),
        .tri_issued_cnt(s_iss), .stall_cnt(s_stall), .bubble_cnt(s_bub));

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction model: a queue of buffered triangles and a frame phase
    typedef struct packed {
        logic [TRI_W-1:0] t;
        logic [COL_W-1:0] c;
        logic             l;
    } ent_t;

    ent_t            q[$];
    int              ph;        // 0 idle, 1 issuing, 2 draining, 3 frame done
    int              dcnt;
    longint unsigned m_iss, m_stall, m_bub;

    function automatic logic [TRI_W-1:0] rand_tri();
        logic [TRI_W-1:0] r = '0;
        for (int i = 0; i < 7; i++) r = {r[TRI_W-33:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [COL_W-1:0] rand_col();
        logic [COL_W-1:0] r = '0;
        for (int i = 0; i < 3; i++) r = {r[COL_W-33:0], 32'($urandom())};
        return r;
    endfunction

    function automatic bit e_valid();
        return (ph == 1) && (q.size() != 0);
    endfunction

    function automatic logic [TRI_W-1:0] e_tri();
        return e_valid() ? q[0].t : '0;
    endfunction

    function automatic logic [COL_W-1:0] e_col();
        return e_valid() ? q[0].c : '0;
    endfunction

    task automatic model_clear();
        q.delete();
        ph = 0; dcnt = 0;
        m_iss = 0; m_stall = 0; m_bub = 0;
    endtask

    // One clock: advance the model on the edge from pre-edge inputs, then settle
    task automatic step();
        bit v, x, psh, nonempty;
        ent_t e;
        @(posedge clk);
        nonempty = (q.size() != 0);
        v   = (ph == 1) && nonempty;
        x   = v && halt_RnnnnL;
        psh = ld_valid && (q.size() < int'(DEPTH));
        if (cnt_clr) begin
            m_iss = 0; m_stall = 0; m_bub = 0;
        end else begin
            if (x && m_iss < MAXC) m_iss++;
            if (v && !halt_RnnnnL && m_stall < MAXC) m_stall++;
            if (ph == 1 && !nonempty && halt_RnnnnL && m_bub < MAXC) m_bub++;
        end
        case (ph)
            0: if (nonempty) ph = 1;
            1: if (x && q[0].l) begin ph = 2; dcnt = 0; end
            2: if (!halt_RnnnnL) dcnt = 0;
               else begin
                   dcnt++;
                   if (dcnt == int'(DC)) begin ph = 3; dcnt = 0; end
               end
            default: ph = 0;
        endcase
        if (x) void'(q.pop_front());
        if (psh) begin
            e.t = ld_tri; e.c = ld_color; e.l = ld_last;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (validTri_R10H) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (frame_done) ok = 1'b1;
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; ld_valid = 1'b0; halt_RnnnnL = 1'b1; cnt_clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (validTri_R10H !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_done got=%b%b exp=00", validTri_R10H, frame_done); end
        n_cmp++; if (ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
        @(negedge clk); rst = 1'b1;
        step();
        n_cmp++; if (tri_R10S !== '0 || color_R10U !== '0) begin
            n_fail++; $display("FAIL reset_data got=%h/%h exp=0", tri_R10S, color_R10U); end
        n_cmp++; if (tri_issued_cnt !== 0 || stall_cnt !== 0 || bubble_cnt !== 0) begin
            n_fail++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                               tri_issued_cnt, stall_cnt, bubble_cnt); end
    endtask

    task automatic test_single();
        int v_cyc = -1, fd_cyc = -1, v_n = 0, fd_n = 0;
        logic [TRI_W-1:0] t = rand_tri();
        halt_RnnnnL = 1'b1; ld_tri = t; ld_color = rand_col(); ld_last = 1'b1; ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        for (int k = 1; k < 25; k++) begin
            if (validTri_R10H) begin
                v_n++; v_cyc = k;
                n_cmp++; if (tri_R10S !== t) begin
                    n_fail++; $display("FAIL single_data got=%h exp=%h", tri_R10S, t); end
            end
            if (frame_done) begin fd_n++; fd_cyc = k; end
            step();
        end
        n_cmp++; if (v_n != 1 || v_cyc != 2) begin
            n_fail++; $display("FAIL single_valid cycles=%0d at=%0d exp=1 at 2", v_n, v_cyc); end
        n_cmp++; if (tri_issued_cnt !== 1) begin
            n_fail++; $display("FAIL single_issued got=%0d exp=1", tri_issued_cnt); end
        n_cmp++; if (fd_n != 1 || fd_cyc - v_cyc != int'(DC) + 1) begin
            n_fail++; $display("FAIL single_frame_done pulses=%0d offset=%0d exp=1 at %0d",
                               fd_n, fd_cyc - v_cyc, DC + 1); end
    endtask

    task automatic test_backpressure();
        logic [TRI_W-1:0] ht;
        logic [COL_W-1:0] hc;
        bit stable = 1'b1, consec = 1'b1, ok;
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_tri = rand_tri(); ld_color = rand_col(); ld_last = (i == 2); ld_valid = 1'b1;
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_valid(ok);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        ht = tri_R10S; hc = color_R10U;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!validTri_R10H || tri_R10S !== ht || color_R10U !== hc) stable = 1'b0;
        end
        n_cmp++; if (!stable || ht !== q[0].t) begin
            n_fail++; $display("FAIL bp_hold stable=%0b head=%h exp=%h", stable, ht, q[0].t); end
        n_cmp++; if (stall_cnt !== 5) begin
            n_fail++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt); end
        halt_RnnnnL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!validTri_R10H) consec = 1'b0;
            step();
        end
        n_cmp++; if (!consec || tri_issued_cnt !== 3) begin
            n_fail++; $display("FAIL bp_transfers consecutive=%0b issued=%0d exp=1/3",
                               consec, tri_issued_cnt); end
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_frame_done got=timeout exp=pulse"); end
    endtask

    task automatic test_full();
        logic [SIGFIG-1:0] obs[5];
        int n = 0;
        bit acc, blocked = 1'b1, ok;
        halt_RnnnnL = 1'b0; ld_color = '0; ld_last = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ld_tri = TRI_W'(i); ld_valid = 1'b1;
            step();
        end
        n_cmp++; if (ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ld_ready got=%b exp=0", ld_ready); end
        ld_tri = TRI_W'(5); ld_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ld_ready !== 1'b0) blocked = 1'b0;
        end
        n_cmp++; if (!blocked || tri_R10S[SIGFIG-1:0] !== SIGFIG'(1)) begin
            n_fail++; $display("FAIL full_blocked blocked=%0b head=%0d exp=1/1",
                               blocked, tri_R10S[SIGFIG-1:0]); end
        halt_RnnnnL = 1'b1;
        for (int i = 0; i < 30 && n < 5; i++) begin
            acc = ld_valid && ld_ready;
            if (validTri_R10H) begin obs[n] = tri_R10S[SIGFIG-1:0]; n++; end
            step();
            if (acc) begin ld_valid = 1'b0; ld_last = 1'b0; end
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (i >= n || obs[i] !== SIGFIG'(i + 1)) begin
                n_fail++; $display("FAIL full_order idx=%0d got=%0d exp=%0d", i,
                                   (i < n) ? int'(obs[i]) : -1, i + 1); end
        end
        ld_valid = 1'b0;
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_frame_done got=timeout exp=pulse"); end
    endtask

    task automatic test_drain();
        int fd_at = -1;
        bit early = 1'b0, ok;
        halt_RnnnnL = 1'b1; ld_tri = rand_tri(); ld_last = 1'b1; ld_valid = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_valid(ok);
        step();
        for (int i = 0; i < 5; i++) begin step(); if (frame_done) early = 1'b1; end
        halt_RnnnnL = 1'b0; step(); if (frame_done) early = 1'b1;
        halt_RnnnnL = 1'b1;
        for (int k = 1; k <= 20 && fd_at < 0; k++) begin
            step();
            if (frame_done) fd_at = k;
        end
        n_cmp++; if (early || fd_at != int'(DC)) begin
            n_fail++; $display("FAIL drain_restart early=%0b done_after=%0d exp=0/%0d", early, fd_at, DC); end
        step();
    endtask

    task automatic test_bubbles();
        bit ok;
        halt_RnnnnL = 1'b1;
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        ld_tri = rand_tri(); ld_last = 1'b0; ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        wait_valid(ok);
        step();
        step(); step();
        ld_tri = rand_tri(); ld_last = 1'b1; ld_valid = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_done(ok);
        n_cmp++; if (bubble_cnt !== 3) begin
            n_fail++; $display("FAIL bubble_cnt got=%0d exp=3", bubble_cnt); end
    endtask

    task automatic test_counters();
        bit ok;
        int fd_n = 0;
        halt_RnnnnL = 1'b1; ld_tri = rand_tri(); ld_last = 1'b0; ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        wait_valid(ok);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        n_cmp++; if (tri_issued_cnt !== 0 || stall_cnt !== 0 || bubble_cnt !== 0) begin
            n_fail++; $display("FAIL clr_priority got=%0d/%0d/%0d exp=0/0/0",
                               tri_issued_cnt, stall_cnt, bubble_cnt); end
        n_cmp++; if (s_iss !== 2'd0) begin
            n_fail++; $display("FAIL clr_priority_narrow got=%0d exp=0", s_iss); end
        for (int i = 0; i < 5; i++) begin
            ld_tri = rand_tri(); ld_last = (i == 4); ld_valid = 1'b1;
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_done(ok);
        n_cmp++; if (tri_issued_cnt !== 5 || s_iss !== 2'd3) begin
            n_fail++; $display("FAIL saturate issued=%0d narrow=%0d exp=5/3", tri_issued_cnt, s_iss); end
        // Reset in the middle of a frame
        for (int i = 0; i < 2; i++) begin
            ld_tri = rand_tri(); ld_last = (i == 1); ld_valid = 1'b1;
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        wait_valid(ok);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (validTri_R10H !== 1'b0 || ld_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset valid/ready/done got=%b%b%b exp=010",
                               validTri_R10H, ld_ready, frame_done); end
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 15; i++) begin step(); if (frame_done) fd_n++; end
        n_cmp++; if (fd_n != 0 || tri_issued_cnt !== 0) begin
            n_fail++; $display("FAIL midreset_no_done pulses=%0d issued=%0d exp=0/0", fd_n, tri_issued_cnt); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            ld_valid    = ($urandom_range(0, 1) == 1);
            halt_RnnnnL = ($urandom_range(0, 9) < 7);
            ld_last     = ($urandom_range(0, 3) == 0);
            cnt_clr     = ($urandom_range(0, 39) == 0);
            ld_tri      = rand_tri();
            ld_color    = rand_col();
            step();
            n_cmp++;
            if (validTri_R10H !== e_valid() || tri_R10S !== e_tri() || color_R10U !== e_col()
                || ld_ready !== (q.size() < int'(DEPTH)) || frame_done !== (ph == 3)) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL random_issue cyc=%0d got v=%b rdy=%b fd=%b tri=%h exp v=%b fd=%b tri=%h",
                             c, validTri_R10H, ld_ready, frame_done, tri_R10S, e_valid(), ph == 3, e_tri());
            end
            n_cmp++;
            if (tri_issued_cnt !== CNT_W'(m_iss) || stall_cnt !== CNT_W'(m_stall)
                || bubble_cnt !== CNT_W'(m_bub)) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL random_counters cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                             tri_issued_cnt, stall_cnt, bubble_cnt, m_iss, m_stall, m_bub);
            end
        end
        cnt_clr = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full();
        test_drain();
        test_bubbles();
        test_counters();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
